// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle Wishbone-classic data-memory master for the RV32I core.
// Decodes load/store instructions, steers store lanes, extends load data, and holds
// busy for one bus transaction at a time.
// Optional build macro: MISALIGNED_TRAP_EN (misaligned halfword/word accesses fault).
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_cyc,
  output logic        mem_stb,
  output logic        mem_we,
  output logic [29:0] mem_adr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [29:0] adr_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addrLo_q;
  logic [31:0] loadData_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        isLoad;
  logic        isStore;
  logic        legal;
  logic        canAccept;
  logic        accept;
  logic [3:0]  selNext;
  logic [31:0] wdataNext;
  logic [31:0] shiftedRdata;
  logic [7:0]  rdByte;
  logic [15:0] rdHalf;
  logic [31:0] loadExt;
  logic        unusedInstrBits;

  assign opcode          = instruction[6:0];
  assign funct3          = instruction[14:12];
  assign unusedInstrBits = ^{instruction[31:15], instruction[11:7]};

  // Request decode: legality check and lane steering for the incoming access
  always_comb begin
    isLoad    = (opcode == 7'b0000011);
    isStore   = (opcode == 7'b0100011);
    legal     = 1'b0;
    selNext   = 4'b1111;
    wdataNext = store_data;
    if (isLoad) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    end else if (isStore) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end
`ifdef MISALIGNED_TRAP_EN
    if ((funct3[1:0] == 2'b01) && addr[0]) legal = 1'b0;
    if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) legal = 1'b0;
`endif
    case (funct3[1:0])
      2'b00: begin
        selNext   = 4'b0001 << addr[1:0];
        wdataNext = {4{store_data[7:0]}};
      end
      2'b01: begin
        selNext   = addr[1] ? 4'b1100 : 4'b0011;
        wdataNext = {2{store_data[15:0]}};
      end
      default: begin
        selNext   = 4'b1111;
        wdataNext = store_data;
      end
    endcase
  end

  // Load extraction from the lane chosen by the address bits latched at start
  always_comb begin
    shiftedRdata = mem_rdata >> {addrLo_q, 3'b000};
    rdByte       = shiftedRdata[7:0];
    rdHalf       = addrLo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  loadExt = {{24{rdByte[7]}}, rdByte};
      3'b100:  loadExt = {24'b0, rdByte};
      3'b001:  loadExt = {{16{rdHalf[15]}}, rdHalf};
      3'b101:  loadExt = {16'b0, rdHalf};
      default: loadExt = mem_rdata;
    endcase
  end

  assign canAccept = (state_q != REQ);
  assign accept    = canAccept && start && legal;

  // Next-state logic: IDLE, DONE and FAULT all accept a new request
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: begin
        if (mem_ack) state_d = DONE;
      end
      default: begin
        if (start) state_d = legal ? REQ : FAULT;
        else       state_d = IDLE;
      end
    endcase
  end

  // State, latched bus request and load result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      addrLo_q   <= '0;
      loadData_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= isStore;
        adr_q    <= addr[31:2];
        sel_q    <= selNext;
        wdata_q  <= wdataNext;
        funct3_q <= funct3;
        addrLo_q <= addr[1:0];
      end
      if ((state_q == REQ) && mem_ack && !we_q) begin
        loadData_q <= loadExt;
      end
    end
  end

  assign busy      = (state_q == REQ);
  assign mem_cyc   = (state_q == REQ);
  assign mem_stb   = (state_q == REQ);
  assign done      = (state_q == DONE) || (state_q == FAULT);
  assign fault     = (state_q == FAULT);
  assign mem_we    = we_q;
  assign mem_adr   = adr_q;
  assign mem_sel   = sel_q;
  assign mem_wdata = wdata_q;
  assign load_data = loadData_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed, table-driven bench for load_store_unit.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] instruction;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic        mem_cyc;
  logic        mem_stb;
  logic        mem_we;
  logic [29:0] mem_adr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ackDelay;
    logic        expFault;
    logic [29:0] expAdr;
    logic [3:0]  expSel;
    logic        expWe;
    logic [31:0] expWdata;
    logic [31:0] expLoad;
  } vec_t;

  vec_t vecs[$];

  load_store_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instruction (instruction),
    .addr        (addr),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .load_data   (load_data),
    .mem_cyc     (mem_cyc),
    .mem_stb     (mem_stb),
    .mem_we      (mem_we),
    .mem_adr     (mem_adr),
    .mem_sel     (mem_sel),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One request from the table: drive at a falling edge, check in REQ, ack after ackDelay
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    start       = 1'b1;
    instruction = v.instr;
    addr        = v.addr;
    store_data  = v.sdata;
    @(negedge clk);
    start       = 1'b0;
    instruction = 32'h0;
    addr        = 32'hFFFF_FFFF;
    store_data  = 32'h0;
    if (v.expFault) begin
      checkOutput({v.name, " done"},  {31'b0, done},    32'd1);
      checkOutput({v.name, " fault"}, {31'b0, fault},   32'd1);
      checkOutput({v.name, " cyc"},   {31'b0, mem_cyc}, 32'd0);
      checkOutput({v.name, " busy"},  {31'b0, busy},    32'd0);
      checkOutput({v.name, " load"},  load_data,        v.expLoad);
      @(negedge clk);
      checkOutput({v.name, " done idle"}, {31'b0, done}, 32'd0);
      return;
    end
    checkOutput({v.name, " cyc"},   {31'b0, mem_cyc}, 32'd1);
    checkOutput({v.name, " stb"},   {31'b0, mem_stb}, 32'd1);
    checkOutput({v.name, " busy"},  {31'b0, busy},    32'd1);
    checkOutput({v.name, " we"},    {31'b0, mem_we},  {31'b0, v.expWe});
    checkOutput({v.name, " adr"},   {2'b0, mem_adr},  {2'b0, v.expAdr});
    checkOutput({v.name, " sel"},   {28'b0, mem_sel}, {28'b0, v.expSel});
    checkOutput({v.name, " wdata"}, mem_wdata,        v.expWdata);
    repeat (v.ackDelay - 1) begin
      @(negedge clk);
      checkOutput({v.name, " wait done"}, {31'b0, done}, 32'd0);
      checkOutput({v.name, " wait cyc"},  {31'b0, mem_cyc}, 32'd1);
    end
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    checkOutput({v.name, " done"},      {31'b0, done},    32'd1);
    checkOutput({v.name, " fault"},     {31'b0, fault},   32'd0);
    checkOutput({v.name, " busy end"},  {31'b0, busy},    32'd0);
    checkOutput({v.name, " cyc end"},   {31'b0, mem_cyc}, 32'd0);
    checkOutput({v.name, " load"},      load_data,        v.expLoad);
    @(negedge clk);
    checkOutput({v.name, " done idle"}, {31'b0, done}, 32'd0);
  endtask

  task automatic addVec(input string name, input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int dly,
                        input logic f, input logic [29:0] adr, input logic [3:0] sel,
                        input logic we, input logic [31:0] wd, input logic [31:0] ld);
    vec_t v;
    v.name = name; v.instr = instr; v.addr = a; v.sdata = sd; v.rdata = rd;
    v.ackDelay = dly; v.expFault = f; v.expAdr = adr; v.expSel = sel; v.expWe = we;
    v.expWdata = wd; v.expLoad = ld;
    vecs.push_back(v);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    instruction = 32'h0;
    addr        = 32'h0;
    store_data  = 32'h0;
    mem_rdata   = 32'h0;
    mem_ack     = 1'b0;

    //      name         instr         addr         sdata        rdata      dly flt adr       sel      we wdata        load
    addVec("SB 0x203",   32'h00000023, 32'h203,     32'h000000A5, 32'h0,       3, 0, 30'h80,  4'b1000, 1, 32'hA5A5A5A5, 32'h0);
    addVec("LB 0x11",    32'h00000003, 32'h11,      32'h0,        32'h00008000,1, 0, 30'h4,   4'b0010, 0, 32'h0,        32'hFFFFFF80);
    addVec("LBU 0x11",   32'h00004003, 32'h11,      32'h0,        32'h00008000,1, 0, 30'h4,   4'b0010, 0, 32'h0,        32'h00000080);
    addVec("LH 0x2",     32'h00001003, 32'h2,       32'h0,        32'hBEEF1234,2, 0, 30'h0,   4'b1100, 0, 32'h0,        32'hFFFFBEEF);
    addVec("LHU 0x2",    32'h00005003, 32'h2,       32'h0,        32'h80017FFF,1, 0, 30'h0,   4'b1100, 0, 32'h0,        32'h00008001);
    addVec("LHU 0x0",    32'h00005003, 32'h0,       32'h0,        32'h80017FFF,1, 0, 30'h0,   4'b0011, 0, 32'h0,        32'h00007FFF);
    addVec("LW 0x4",     32'h00002003, 32'h4,       32'h0,        32'hCAFEBABE,1, 0, 30'h1,   4'b1111, 0, 32'h0,        32'hCAFEBABE);
    addVec("SH 0x6",     32'h00001023, 32'h6,       32'h1234ABCD, 32'h0,       2, 0, 30'h1,   4'b1100, 1, 32'hABCDABCD, 32'hCAFEBABE);
    addVec("SW 0x100",   32'h00002023, 32'h100,     32'hDEADBEEF, 32'h0,       1, 0, 30'h40,  4'b1111, 1, 32'hDEADBEEF, 32'hCAFEBABE);
    addVec("LB 0x20",    32'h00000003, 32'h20,      32'h0,        32'h1234567F,1, 0, 30'h8,   4'b0001, 0, 32'h0,        32'h0000007F);
    addVec("SB 0x1",     32'h00000023, 32'h1,       32'h0000005A, 32'h0,       1, 0, 30'h0,   4'b0010, 1, 32'h5A5A5A5A, 32'h0000007F);
    addVec("LD f3=011",  32'h00003003, 32'h8,       32'h0,        32'h0,       1, 1, 30'h0,   4'b0000, 0, 32'h0,        32'h0000007F);
    addVec("R-type",     32'h00000033, 32'h8,       32'h0,        32'h0,       1, 1, 30'h0,   4'b0000, 0, 32'h0,        32'h0000007F);
    addVec("ST f3=100",  32'h00004023, 32'h8,       32'h0,        32'h0,       1, 1, 30'h0,   4'b0000, 0, 32'h0,        32'h0000007F);
`ifdef MISALIGNED_TRAP_EN
    addVec("LW 0x6",     32'h00002003, 32'h6,       32'h0,        32'h11223344,1, 1, 30'h0,   4'b0000, 0, 32'h0,        32'h0000007F);
`else
    addVec("LW 0x6",     32'h00002003, 32'h6,       32'h0,        32'h11223344,1, 0, 30'h1,   4'b1111, 0, 32'h0,        32'h11223344);
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst busy",  {31'b0, busy},    32'd0);
    checkOutput("rst done",  {31'b0, done},    32'd0);
    checkOutput("rst fault", {31'b0, fault},   32'd0);
    checkOutput("rst cyc",   {31'b0, mem_cyc}, 32'd0);
    checkOutput("rst we",    {31'b0, mem_we},  32'd0);
    checkOutput("rst sel",   {28'b0, mem_sel}, 32'd0);
    checkOutput("rst adr",   {2'b0, mem_adr},  32'd0);
    checkOutput("rst load",  load_data,        32'd0);
    rst_n = 1'b1;

    // Ack while idle is ignored
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("idle ack done", {31'b0, done}, 32'd0);
    checkOutput("idle ack load", load_data,     32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Back-to-back: LH, then LW started in the DONE cycle and acked immediately
    @(negedge clk);
    start = 1'b1; instruction = 32'h00001003; addr = 32'h2;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBEEF1234;
    @(negedge clk);
    checkOutput("b2b LH done", {31'b0, done}, 32'd1);
    checkOutput("b2b LH load", load_data,     32'hFFFFBEEF);
    mem_ack = 1'b0;
    start = 1'b1; instruction = 32'h00002003; addr = 32'h4;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b LW cyc", {31'b0, mem_cyc}, 32'd1);
    checkOutput("b2b LW adr", {2'b0, mem_adr},  32'd1);
    checkOutput("b2b LW sel", {28'b0, mem_sel}, 32'hF);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("b2b LW done", {31'b0, done}, 32'd1);
    checkOutput("b2b LW load", load_data,     32'h0BADF00D);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; instruction = 32'h00002023; addr = 32'h100; store_data = 32'h1;
    @(negedge clk);
    instruction = 32'h00000003; addr = 32'h33;
    repeat (2) @(negedge clk);
    start = 1'b0;
    checkOutput("busy ign adr", {2'b0, mem_adr},  32'h40);
    checkOutput("busy ign we",  {31'b0, mem_we},  32'd1);
    checkOutput("busy ign sel", {28'b0, mem_sel}, 32'hF);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("busy ign done", {31'b0, done}, 32'd1);
    checkOutput("busy ign load", load_data,     32'h0BADF00D);
    @(negedge clk);
    checkOutput("busy ign no restart", {31'b0, mem_cyc}, 32'd0);

    // Reset in the middle of a request
    start = 1'b1; instruction = 32'h00002023; addr = 32'h100; store_data = 32'h77;
    @(negedge clk);
    start = 1'b0;
    checkOutput("midrst cyc before", {31'b0, mem_cyc}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst cyc",  {31'b0, mem_cyc}, 32'd0);
    checkOutput("midrst stb",  {31'b0, mem_stb}, 32'd0);
    checkOutput("midrst busy", {31'b0, busy},    32'd0);
    checkOutput("midrst done", {31'b0, done},    32'd0);
    checkOutput("midrst load", load_data,        32'd0);
    mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("midrst late ack done", {31'b0, done}, 32'd0);
    end
    mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
